// File: rtl/wm_pixel_sequencer_if.sv
// Memory-port and blend-unit signal bundle for the watermark pixel sequencer.
// The master side is the sequencer. The slave side is the memory/APB
// arbitration environment and the blend unit.
interface wm_pixel_sequencer_if #(
    parameter int Data_Depth      = 8,
    parameter int amba_addr_depth = 20
);
    logic                       apb_req;
    logic                       apb_gnt;
    logic                       mem_rd_en;
    logic [amba_addr_depth-1:0] mem_addr;
    logic [Data_Depth-1:0]      mem_rdata;
    logic                       blend_start;
    logic [Data_Depth-1:0]      blend_host;
    logic [Data_Depth-1:0]      blend_wm;
    logic                       blend_done;
    logic [Data_Depth-1:0]      blend_result;

    modport master (
        input  apb_req, mem_rdata, blend_done, blend_result,
        output apb_gnt, mem_rd_en, mem_addr, blend_start, blend_host, blend_wm
    );

    modport slave (
        output apb_req, mem_rdata, blend_done, blend_result,
        input  apb_gnt, mem_rd_en, mem_addr, blend_start, blend_host, blend_wm
    );
endinterface

// File: rtl/wm_pixel_sequencer.sv
// Visible-watermarking pixel sequencer.
// The sequencer walks an M x M host image in raster order. For pixels in the
// bottom-right N x N corner it also fetches a watermark pixel and blends the
// two. It shares one memory read port with an APB slave. The APB slave has
// priority, and a starvation counter guarantees the sequencer eventually
// gets the port.
module wm_pixel_sequencer #(
    parameter int Data_Depth      = 8,
    parameter int amba_addr_depth = 20,
    parameter int Cnt_W           = 10,
    parameter int Starve_Lim      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [Cnt_W-1:0]           cfg_m,
    input  logic [Cnt_W-1:0]           cfg_n,
    input  logic [amba_addr_depth-1:0] cfg_wm_base,
    wm_pixel_sequencer_if.master       bus,
    output logic [Data_Depth-1:0]      Pixel_Data,
    output logic                       new_pixel,
    output logic                       Image_Done,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int IDX_W = 2 * Cnt_W;
    localparam int STV_W = $clog2(Starve_Lim + 1);

    typedef enum logic [2:0] {
        IDLE, H_REQ, H_CAP, W_REQ, W_CAP, BL_WAIT, EMIT, DONE
    } state_t;

    state_t                     state;
    logic [Cnt_W-1:0]           m_q;
    logic [Cnt_W-1:0]           n_q;
    logic [amba_addr_depth-1:0] base_q;
    logic [Cnt_W-1:0]           row;
    logic [Cnt_W-1:0]           col;
    logic [IDX_W-1:0]           hidx;
    logic [IDX_W-1:0]           widx;
    logic [STV_W-1:0]           starve_cnt;
    logic [Data_Depth-1:0]      host_q;
    logic [Data_Depth-1:0]      wm_q;
    logic                       blend_start_q;

    logic [Cnt_W-1:0]           region_lo;
    logic                       in_region;
    logic                       last_col;
    logic                       last_row;
    logic                       seq_req;
    logic                       starved;
    logic                       apb_gnt_c;
    logic                       seq_gnt;
    logic [amba_addr_depth-1:0] mem_addr_c;

    // Region test, raster-position flags and memory-port arbitration.
    // APB wins unless the sequencer has been denied Starve_Lim times in a row.
    // apb_gnt is gated by reset so every output reads 0 while reset is held.
    always_comb begin
        region_lo  = m_q - n_q;
        in_region  = (n_q != '0) && (row >= region_lo) && (col >= region_lo);
        last_col   = (col == m_q - Cnt_W'(1));
        last_row   = (row == m_q - Cnt_W'(1));
        seq_req    = (state == H_REQ) || (state == W_REQ);
        starved    = seq_req && (starve_cnt >= STV_W'(Starve_Lim));
        apb_gnt_c  = rst && bus.apb_req && !starved;
        seq_gnt    = seq_req && !apb_gnt_c;
        mem_addr_c = '0;
        if (seq_gnt) begin
            if (state == W_REQ) begin
                mem_addr_c = base_q + amba_addr_depth'(widx);
            end else begin
                mem_addr_c = amba_addr_depth'(hidx);
            end
        end
    end

    assign bus.apb_gnt     = apb_gnt_c;
    assign bus.mem_rd_en   = seq_gnt;
    assign bus.mem_addr    = mem_addr_c;
    assign bus.blend_start = blend_start_q;
    assign bus.blend_host  = host_q;
    assign bus.blend_wm    = wm_q;

    // Count consecutive denied request cycles. The count clears on a grant
    // or when the sequencer stops requesting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (seq_req && !seq_gnt) begin
            starve_cnt <= starve_cnt + STV_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

    // Main pixel FSM. It handles fetch, optional blend, emit and raster
    // advance. All outputs are registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            m_q           <= '0;
            n_q           <= '0;
            base_q        <= '0;
            row           <= '0;
            col           <= '0;
            hidx          <= '0;
            widx          <= '0;
            host_q        <= '0;
            wm_q          <= '0;
            blend_start_q <= 1'b0;
            Pixel_Data    <= '0;
            new_pixel     <= 1'b0;
            Image_Done    <= 1'b0;
            busy          <= 1'b0;
            cfg_err       <= 1'b0;
        end else begin
            blend_start_q <= 1'b0;
            new_pixel     <= 1'b0;
            Image_Done    <= 1'b0;
            cfg_err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if ((cfg_m == '0) || (cfg_n > cfg_m)) begin
                            cfg_err <= 1'b1;
                        end else begin
                            m_q    <= cfg_m;
                            n_q    <= cfg_n;
                            base_q <= cfg_wm_base;
                            row    <= '0;
                            col    <= '0;
                            hidx   <= '0;
                            widx   <= '0;
                            busy   <= 1'b1;
                            state  <= H_REQ;
                        end
                    end
                end
                H_REQ: begin
                    if (seq_gnt) state <= H_CAP;
                end
                H_CAP: begin
                    host_q <= bus.mem_rdata;
                    if (in_region) begin
                        state <= W_REQ;
                    end else begin
                        Pixel_Data <= bus.mem_rdata;
                        new_pixel  <= 1'b1;
                        state      <= EMIT;
                    end
                end
                W_REQ: begin
                    if (seq_gnt) state <= W_CAP;
                end
                W_CAP: begin
                    wm_q          <= bus.mem_rdata;
                    blend_start_q <= 1'b1;
                    state         <= BL_WAIT;
                end
                BL_WAIT: begin
                    if (bus.blend_done) begin
                        Pixel_Data <= bus.blend_result;
                        new_pixel  <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    hidx <= hidx + IDX_W'(1);
                    if (in_region) widx <= widx + IDX_W'(1);
                    if (last_col) begin
                        col <= '0;
                        row <= row + Cnt_W'(1);
                    end else begin
                        col <= col + Cnt_W'(1);
                    end
                    if (last_col && last_row) begin
                        Image_Done <= 1'b1;
                        state      <= DONE;
                    end else begin
                        state <= H_REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wm_pixel_sequencer.sv
// Self-checking bench for wm_pixel_sequencer.
// It runs table-driven image passes against a memory model and a blend
// model, followed by hand-written starvation, reset and disturbance
// sequences.
module tb_wm_pixel_sequencer;

    localparam int DD = 8;
    localparam int AD = 20;
    localparam int CW = 10;

    typedef struct {
        int m;
        int n;
        int base;
        int disturb;
        int exp_err;
        int exp_pix;
        int exp_blend;
        int exp_cycles;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] cfg_m = '0;
    logic [CW-1:0] cfg_n = '0;
    logic [AD-1:0] cfg_wm_base = '0;
    logic [DD-1:0] Pixel_Data;
    logic          new_pixel;
    logic          Image_Done;
    logic          busy;
    logic          cfg_err;

    logic apb_req_tb = 1'b0;
    logic bd_model = 1'b0;
    logic bd_inject = 1'b0;
    logic blend_enable = 1'b1;

    wm_pixel_sequencer_if #(.Data_Depth(DD), .amba_addr_depth(AD)) bus();

    wm_pixel_sequencer #(
        .Data_Depth(DD), .amba_addr_depth(AD), .Cnt_W(CW), .Starve_Lim(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_wm_base(cfg_wm_base),
        .bus(bus),
        .Pixel_Data(Pixel_Data), .new_pixel(new_pixel),
        .Image_Done(Image_Done), .busy(busy), .cfg_err(cfg_err)
    );

    assign bus.apb_req    = apb_req_tb;
    assign bus.blend_done = bd_model | bd_inject;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] mem [0:2047];
    vec_t vecs [7];

    logic [7:0] pix_q [$];
    int rd_q [$];
    logic [7:0] exp_pix [$];
    int exp_wm [$];
    int n_blend, n_rd, n_done, n_err, n_busy, n_excl;
    int first_busy, last_pix_cyc, done_cyc;

    int bl_cnt = 0;
    logic [7:0] bh = '0;
    logic [7:0] bw = '0;

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model. Read data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr[10:0]];
    end

    // Blend model. It returns host^wm a fixed number of cycles after
    // blend_start.
    always @(posedge clk) begin
        bd_model <= 1'b0;
        if (bl_cnt != 0) begin
            bl_cnt <= bl_cnt - 1;
            if (bl_cnt == 1) begin
                bd_model         <= 1'b1;
                bus.blend_result <= bh ^ bw;
            end
        end else if (bus.blend_start && blend_enable) begin
            bl_cnt <= 2;
            bh     <= bus.blend_host;
            bw     <= bus.blend_wm;
        end
    end

    // Monitor. It samples DUT outputs on the falling edge.
    always @(negedge clk) begin
        if (new_pixel) begin
            pix_q.push_back(Pixel_Data);
            last_pix_cyc = cyc;
        end
        if (bus.blend_start) n_blend++;
        if (bus.mem_rd_en) begin
            n_rd++;
            rd_q.push_back(int'(bus.mem_addr));
        end
        if (bus.mem_rd_en && bus.apb_gnt) n_excl++;
        if (Image_Done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (cfg_err) n_err++;
        if (busy) begin
            n_busy++;
            if (first_busy < 0) first_busy = cyc;
        end
    end

    // Backstop so the bench can never hang.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic clearMonitor();
        @(posedge clk);
        #1;
        pix_q.delete();
        rd_q.delete();
        n_blend = 0; n_rd = 0; n_done = 0; n_err = 0; n_busy = 0; n_excl = 0;
        first_busy = -1; last_pix_cyc = 0; done_cyc = 0;
    endtask

    task automatic pulseStart(input int m, input int n, input int base);
        @(negedge clk);
        cfg_m = CW'(m);
        cfg_n = CW'(n);
        cfg_wm_base = AD'(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(input int limit);
        for (int t = 0; t < limit; t++) begin
            @(negedge clk);
            if (Image_Done) break;
        end
    endtask

    // Reference model. It lists the pixels and watermark addresses one
    // pass should produce.
    task automatic buildExpected(input vec_t v);
        int w;
        int r;
        int c;
        exp_pix.delete();
        exp_wm.delete();
        w = 0;
        if (v.exp_err == 0) begin
            for (int k = 0; k < v.m * v.m; k++) begin
                r = k / v.m;
                c = k % v.m;
                if (v.n != 0 && r >= v.m - v.n && c >= v.m - v.n) begin
                    exp_pix.push_back(mem[k] ^ mem[v.base + w]);
                    exp_wm.push_back(v.base + w);
                    w++;
                end else begin
                    exp_pix.push_back(mem[k]);
                end
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int wm_seen [$];
        logic injected;
        logic inj_active;
        injected = 1'b0;
        inj_active = 1'b0;
        buildExpected(v);
        clearMonitor();
        pulseStart(v.m, v.n, v.base);
        for (int t = 0; t < ((v.exp_err != 0) ? 10 : 3000); t++) begin
            @(negedge clk);
            if (inj_active) begin
                bd_inject = 1'b0;
                inj_active = 1'b0;
            end
            if (v.disturb != 0) begin
                if (t == 6) begin
                    cfg_m = CW'(2);
                    start = 1'b1;
                end
                if (t == 7) begin
                    cfg_m = CW'(v.m);
                    start = 1'b0;
                end
                if (!injected && t > 10 && bus.mem_rd_en && bus.mem_addr < 16) begin
                    bd_inject = 1'b1;
                    inj_active = 1'b1;
                    injected = 1'b1;
                end
            end
            if (Image_Done) break;
        end
        bd_inject = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput($sformatf("v%0d_cfg_err", idx), n_err, v.exp_err);
        checkOutput($sformatf("v%0d_done", idx), n_done, (v.exp_err != 0) ? 0 : 1);
        checkOutput($sformatf("v%0d_npix", idx), pix_q.size(), v.exp_pix);
        checkOutput($sformatf("v%0d_nblend", idx), n_blend, v.exp_blend);
        checkOutput($sformatf("v%0d_excl", idx), n_excl, 0);
        checkOutput($sformatf("v%0d_busy_end", idx), int'(busy), 0);
        if (v.exp_err != 0) begin
            checkOutput($sformatf("v%0d_busy_cycles", idx), n_busy, 0);
            checkOutput($sformatf("v%0d_reads", idx), n_rd, 0);
        end else begin
            checkOutput($sformatf("v%0d_done_gap", idx), done_cyc - last_pix_cyc, 1);
        end
        if (v.exp_cycles != 0) begin
            checkOutput($sformatf("v%0d_cycles", idx), last_pix_cyc - first_busy + 1, v.exp_cycles);
        end
        for (int k = 0; k < exp_pix.size(); k++) begin
            if (k < pix_q.size()) begin
                checkOutput($sformatf("v%0d_pix%0d", idx, k), int'(pix_q[k]), int'(exp_pix[k]));
            end
        end
        foreach (rd_q[i]) begin
            if (rd_q[i] >= 'h100) wm_seen.push_back(rd_q[i]);
        end
        checkOutput($sformatf("v%0d_nwm", idx), wm_seen.size(), exp_wm.size());
        for (int k = 0; k < exp_wm.size(); k++) begin
            if (k < wm_seen.size()) begin
                checkOutput($sformatf("v%0d_wm%0d", idx, k), wm_seen[k], exp_wm[k]);
            end
        end
    endtask

    initial begin
        logic exp_rd;
        int exp_addr;
        int pre_busy;

        for (int i = 0; i < 2048; i++) begin
            mem[i] = (i < 256) ? i[7:0] : (8'hA0 + i[7:0]);
        end

        //           m  n  base  dist err pix bl cycles
        vecs[0] = '{4, 0, 'h100, 0, 0, 16, 0, 48};
        vecs[1] = '{4, 2, 'h100, 0, 0, 16, 4, 0};
        vecs[2] = '{3, 4, 'h100, 0, 1, 0,  0, 0};
        vecs[3] = '{0, 0, 'h100, 0, 1, 0,  0, 0};
        vecs[4] = '{2, 1, 'h100, 0, 0, 4,  1, 0};
        vecs[5] = '{3, 3, 'h200, 0, 0, 9,  9, 0};
        vecs[6] = '{4, 2, 'h100, 1, 0, 16, 4, 0};

        // Reset state. apb_req is held high to show that reset gates apb_gnt.
        apb_req_tb = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_new_pixel", int'(new_pixel), 0);
        checkOutput("rst_pixel", int'(Pixel_Data), 0);
        checkOutput("rst_done", int'(Image_Done), 0);
        checkOutput("rst_cfg_err", int'(cfg_err), 0);
        checkOutput("rst_rd_en", int'(bus.mem_rd_en), 0);
        checkOutput("rst_apb_gnt", int'(bus.apb_gnt), 0);
        rst = 1'b1;
        apb_req_tb = 1'b0;
        repeat (2) @(negedge clk);
        $display("[TB] reset released, running vector table");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i], i);
            if (i == 1) begin
                // Hand-computed blended pixels for M=4, N=2, base 0x100.
                if (pix_q.size() == 16) begin
                    checkOutput("hand_pix9", int'(pix_q[9]), 'h09);
                    checkOutput("hand_pix10", int'(pix_q[10]), 'hAA);
                    checkOutput("hand_pix11", int'(pix_q[11]), 'hAA);
                    checkOutput("hand_pix14", int'(pix_q[14]), 'hAC);
                    checkOutput("hand_pix15", int'(pix_q[15]), 'hAC);
                end
            end
        end

        // Starvation: APB holds the port. The sequencer should get one read
        // after each run of 4 denied cycles in H_REQ.
        $display("[TB] starvation sequence");
        clearMonitor();
        @(negedge clk);
        cfg_m = CW'(2);
        cfg_n = CW'(0);
        cfg_wm_base = AD'('h100);
        start = 1'b1;
        apb_req_tb = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i > 1) @(negedge clk);
            exp_rd = (i == 5) || (i == 12) || (i == 19);
            checkOutput($sformatf("stv_rd%0d", i), int'(bus.mem_rd_en), int'(exp_rd));
            checkOutput($sformatf("stv_gnt%0d", i), int'(bus.apb_gnt), int'(!exp_rd));
            if (exp_rd) begin
                exp_addr = (i - 5) / 7;
                checkOutput($sformatf("stv_addr%0d", i), int'(bus.mem_addr), exp_addr);
            end
        end
        apb_req_tb = 1'b0;
        waitDone(200);
        repeat (2) @(negedge clk);
        checkOutput("stv_done", n_done, 1);
        checkOutput("stv_npix", pix_q.size(), 4);
        checkOutput("stv_excl", n_excl, 0);
        for (int k = 0; k < 4; k++) begin
            if (k < pix_q.size()) checkOutput($sformatf("stv_pix%0d", k), int'(pix_q[k]), k);
        end

        // Reset while the sequencer is waiting on the blend unit.
        $display("[TB] reset during blend wait");
        blend_enable = 1'b0;
        clearMonitor();
        pulseStart(2, 1, 'h100);
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.blend_start) break;
        end
        repeat (3) @(negedge clk);
        pre_busy = int'(busy);
        checkOutput("bl_wait_busy", pre_busy, 1);
        checkOutput("bl_wait_nblend", n_blend, 1);
        apb_req_tb = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_busy", int'(busy), 0);
        checkOutput("arst_pixel", int'(Pixel_Data), 0);
        checkOutput("arst_new_pixel", int'(new_pixel), 0);
        checkOutput("arst_done", int'(Image_Done), 0);
        checkOutput("arst_blend_start", int'(bus.blend_start), 0);
        checkOutput("arst_blend_host", int'(bus.blend_host), 0);
        checkOutput("arst_blend_wm", int'(bus.blend_wm), 0);
        checkOutput("arst_rd_en", int'(bus.mem_rd_en), 0);
        checkOutput("arst_addr", int'(bus.mem_addr), 0);
        checkOutput("arst_apb_gnt", int'(bus.apb_gnt), 0);
        repeat (2) @(negedge clk);
        checkOutput("arst_no_partial_done", n_done, 0);
        rst = 1'b1;
        apb_req_tb = 1'b0;
        blend_enable = 1'b1;
        applyStimulus(vecs[4], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wm_pixel_sequencer.md
Name: wm_pixel_sequencer

Overview:
- Controller that sequences the Visible_Watermarking pixel datapath.
- Walks an M x M host image in raster order and fetches each host pixel from the shared pixel memory. For pixels inside the N x N watermark region (bottom-right corner) it also fetches the watermark pixel.
- In-region pixels are sent to the blend unit; all others pass through. Results stream out on Pixel_Data/new_pixel and Image_Done marks the end.
- Also arbitrates the single memory read port between the APB slave (priority) and itself, with a starvation guard.

Parameters:
Data_Depth  8   pixel width in bits
amba_addr_depth  20   memory address width
Cnt_W  10   width of dimension configuration and row/column counters
Starve_Lim  4   consecutive stalled cycles after which the sequencer wins the memory port

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin an image pass
cfg_m  in  Cnt_W  host image side M
cfg_n  in  Cnt_W  watermark side N
cfg_wm_base  in  amba_addr_depth  watermark base address in memory
apb_req  in  1  APB slave requests the memory port this cycle
apb_gnt  out  1  APB owns the memory port this cycle
mem_rd_en  out  1  sequencer read strobe
mem_addr  out  amba_addr_depth  sequencer read address
mem_rdata  in  Data_Depth  read data, valid exactly 1 cycle after mem_rd_en
blend_start  out  1  one-cycle pulse; blend operands valid
blend_host  out  Data_Depth  host pixel operand
blend_wm  out  Data_Depth  watermark pixel operand
blend_done  in  1  one-cycle pulse; blend_result valid
blend_result  in  Data_Depth  blended pixel
Pixel_Data  out  Data_Depth  output pixel
new_pixel  out  1  one-cycle pulse; Pixel_Data valid
Image_Done  out  1  one-cycle pulse after the last pixel
busy  out  1  high from accepted start until Image_Done
cfg_err  out  1  one-cycle pulse; start rejected

Behaviour:
- Reset: rst low asynchronously clears every output to 0, the FSM to IDLE and all counters, including mid-pass. No partial Image_Done is produced.
- FSM states: IDLE, H_REQ, H_CAP, W_REQ, W_CAP, BL_WAIT, EMIT, DONE.
- IDLE, on start:
  - cfg_m==0 or cfg_n>cfg_m: pulse cfg_err next cycle, stay in IDLE.
  - Otherwise: latch M, N and base; clear row r, column c, host index hidx and watermark index widx; set busy; go to H_REQ.
  - start outside IDLE is ignored.
- Region test: inreg = (r >= M-N) && (c >= M-N). N==0 means no pixel is in region.
- H_REQ: when granted, drive mem_rd_en=1 and mem_addr=hidx (zero-extended), then go to H_CAP. When not granted, hold the state.
- H_CAP: register mem_rdata into the host register. If inreg go to W_REQ; otherwise load the output register with the host pixel and go to EMIT.
- W_REQ: when granted, mem_rd_en=1 and mem_addr=cfg_wm_base+widx (modulo 2^amba_addr_depth), then go to W_CAP.
- W_CAP: register the watermark pixel, pulse blend_start with both operands, go to BL_WAIT.
- BL_WAIT: wait an unbounded time for blend_done, then register blend_result and go to EMIT. blend_done in any other state is ignored.
- EMIT: Pixel_Data is registered and new_pixel=1 for exactly this cycle.
  - hidx+1; widx+1 if inreg.
  - c+1; when c==M-1, c returns to 0 and r increments.
  - Last pixel (r==M-1, c==M-1): go to DONE. Otherwise go to H_REQ.
- DONE: Image_Done=1 for one cycle, clear busy, go to IDLE. Pixel_Data holds its last value.
- Minimum latency per pixel: 3 cycles pass-through (H_REQ, H_CAP, EMIT); 5 cycles plus blend latency in region.
- Arbitration:
  - The sequencer requests only in H_REQ or W_REQ.
  - apb_gnt = apb_req unless the starvation counter has reached Starve_Lim while the sequencer is requesting; in that cycle apb_gnt=0 and the sequencer is granted.
  - The starvation counter increments on each cycle the sequencer requests and is denied, and clears when the sequencer is granted or leaves H_REQ/W_REQ.
  - mem_rd_en and apb_gnt are never both 1.

Test Plan:
- M=4, N=0, memory[i]=i: 16 new_pixel pulses with Pixel_Data 0..15 in order, no blend_start, Image_Done one cycle after the 16th pulse, 48 cycles from H_REQ to the last EMIT.
- M=4, N=2, base=0x100, blend returning host^wm after 2 cycles:
  - blend_start only for indices 10, 11, 14, 15, with wm addresses 0x100..0x103 in order.
  - Outputs at those indices equal host^wm; all other outputs equal the host pixel.
- apb_req held high for 20 cycles during H_REQ: apb_gnt=1 for 4 cycles, then 1 cycle with apb_gnt=0 and mem_rd_en=1, then the pattern repeats; mem_rd_en and apb_gnt never both 1.
- start with cfg_m=3, cfg_n=4 (and separately cfg_m=0): cfg_err pulses once, busy stays 0, no memory reads.
- rst low while in BL_WAIT: all outputs 0 immediately; a later start with M=2, N=1 produces 4 pixels and Image_Done normally.
- start re-pulsed mid-pass and blend_done pulsed in H_REQ: both ignored, pixel order and count unchanged.
